// File: rtl/gmm_pkg.sv
// rtl/gmm_pkg.sv - float32 field constants shared by the GMM pixel pipeline
package gmm_pkg;

  localparam int FP_W       = 32;
  localparam int EXP_MSB    = 30;
  localparam int EXP_LSB    = 23;
  localparam int MAN_W      = 23;
  localparam int BIAS       = 127;
  localparam int U8_SAT_EXP = 134;

  typedef logic [FP_W-1:0] fp32_t;

endpackage

// File: rtl/fp_to_u8_sat.sv
// rtl/fp_to_u8_sat.sv - combinational float32 magnitude to saturated u8 (floor)
module fp_to_u8_sat
  import gmm_pkg::*;
(
  input  logic [FP_W-1:0] i_fp,
  output logic [7:0]      o_u8
);

  logic [EXP_MSB-EXP_LSB:0] w_exp;
  logic [MAN_W-1:0]         w_man;
  logic [7:0]               w_shift;
  logic                     w_unused_sign;

  assign w_exp         = i_fp[EXP_MSB:EXP_LSB];
  assign w_man         = i_fp[MAN_W-1:0];
  assign w_unused_sign = i_fp[FP_W-1];

  // Right shift keeps the k+1 integer bits of 1.m for exponent 127+k.
  assign w_shift = 8'(MAN_W) - (w_exp - 8'(BIAS));

  always_comb begin
    o_u8 = '0;
    if (w_exp > 8'(U8_SAT_EXP)) begin
      o_u8 = 8'hFF;
    end else if (w_exp >= 8'(BIAS)) begin
      o_u8 = 8'({1'b1, w_man} >> w_shift);
    end
  end

endmodule

// File: rtl/fp_u8_conv_arbiter.sv
// rtl/fp_u8_conv_arbiter.sv - round-robin shared float32-to-u8 converter with
// one registered, ID-tagged output stage and a wrapping conversion counter
module fp_u8_conv_arbiter
  import gmm_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ),
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [FP_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  out_valid,
  output logic [7:0]            out_data,
  output logic [ID_W-1:0]       out_id,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      conv_count
);

  logic             r_rst_meta;
  logic             r_rst_sync;
  logic             r_out_valid;
  logic [7:0]       r_out_data;
  logic [ID_W-1:0]  r_out_id;
  logic [CNT_W-1:0] r_cnt;
  logic [ID_W-1:0]  r_rr_ptr;

  logic [FP_W-1:0]  w_req_word [N_REQ];
  logic [FP_W-1:0]  w_sel_word;
  logic [7:0]       w_conv;
  logic             w_accept;
  logic             w_any;
  logic             w_fire;
  logic [ID_W-1:0]  w_grant;
  logic [ID_W-1:0]  w_next_ptr;
  logic [ID_W:0]    w_sum;
  logic [ID_W-1:0]  w_cand;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign w_req_word[i] = req_data[FP_W*i +: FP_W];
  end

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    w_sum   = '0;
    w_cand  = '0;
    for (int j = 0; j < N_REQ; j++) begin
      w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(j);
      if (w_sum >= (ID_W+1)'(N_REQ)) begin
        w_sum = w_sum - (ID_W+1)'(N_REQ);
      end
      w_cand = w_sum[ID_W-1:0];
      if (!w_any && req_valid[w_cand]) begin
        w_any   = 1'b1;
        w_grant = w_cand;
      end
    end
  end

  assign w_accept   = !r_out_valid || out_ready;
  assign w_fire     = w_accept && w_any;
  assign w_next_ptr = (w_grant == ID_W'(N_REQ-1)) ? '0 : w_grant + 1'b1;
  assign w_sel_word = w_req_word[w_grant];

  always_comb begin
    req_ready = '0;
    if (r_rst_sync && w_fire) begin
      req_ready[w_grant] = 1'b1;
    end
  end

  fp_to_u8_sat u_conv (
    .i_fp (w_sel_word),
    .o_u8 (w_conv)
  );

  always_ff @(posedge clk or negedge r_rst_sync) begin
    if (!r_rst_sync) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= '0;
      r_cnt       <= '0;
      r_rr_ptr    <= '0;
    end else if (w_accept) begin
      r_out_valid <= w_any;
      if (w_any) begin
        r_out_data <= w_conv;
        r_out_id   <= w_grant;
        r_rr_ptr   <= w_next_ptr;
        r_cnt      <= r_cnt + 1'b1;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_id     = r_out_id;
  assign conv_count = r_cnt;

endmodule

// File: tb/tb_fp_u8_conv_arbiter.sv
// tb/tb_fp_u8_conv_arbiter.sv - scoreboard bench for fp_u8_conv_arbiter
module tb_fp_u8_conv_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid;
  logic [32*N-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [7:0]      out_data;
  logic [1:0]      out_id;
  logic            out_ready;
  logic [15:0]     conv_count;
  logic [31:0]     d [N];

  int          n_checks = 0;
  int          n_err = 0;
  int          m_ptr = 0;
  logic [15:0] m_cnt = '0;
  logic        m_valid = 1'b0;
  logic [9:0]  q [$];
  int          last_grant = -1;
  bit          hold_chk = 1'b0;
  logic [N-1:0] pv = '0;
  logic [N-1:0] pr = '0;
  logic [31:0]  pd [N];

  fp_u8_conv_arbiter #(.N_REQ(4), .ID_W(2), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_id     (out_id),
    .out_ready  (out_ready),
    .conv_count (conv_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < N; i++) req_data[32*i +: 32] = d[i];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Floor of |x| saturated to 255: value = (2^23 + m) * 2^(e-150).
  function automatic logic [7:0] ref_conv(input logic [31:0] f);
    int e;
    longint mag;
    e = int'(f[30:23]);
    if (e >= 135) return 8'd255;
    if (e < 127) return 8'd0;
    mag = (longint'(1) << 23) + longint'(f[22:0]);
    return 8'(mag >> (150 - e));
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int j = 0; j < N; j++) begin
      if (v[(ptr + j) % N]) return (ptr + j) % N;
    end
    return -1;
  endfunction

  function automatic logic [31:0] rand_fp();
    int s;
    logic sg;
    s  = $urandom_range(0, 7);
    sg = 1'($urandom);
    case (s)
      0:       return {sg, 31'h0};
      1:       return {sg, 8'hFF, 23'($urandom)};
      2:       return {sg, 8'($urandom_range(0, 126)), 23'($urandom)};
      default: return {sg, 8'($urandom_range(127, 137)), 23'($urandom)};
    endcase
  endfunction

  // One clock: predict handshake at negedge, then settle after posedge.
  task automatic tick();
    int g;
    logic acc;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    check("out_valid", 32'(out_valid), 32'(m_valid));
    acc = !m_valid || out_ready;
    g = pick(req_valid, m_ptr);
    exp_rdy = (acc && g >= 0) ? N'(1 << g) : '0;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    last_grant = -1;
    if (acc) begin
      if (g >= 0) begin
        q.push_back({2'(g), ref_conv(d[g])});
        m_ptr = (g + 1) % N;
        m_cnt = m_cnt + 16'd1;
        last_grant = g;
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check("conv_count", 32'(conv_count), 32'(m_cnt));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_id", 32'(out_id), 32'd0);
    check("rst_conv_count", 32'(conv_count), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    q.delete();
    m_ptr = 0;
    m_cnt = '0;
    m_valid = 1'b0;
    req_valid = '0;
    #4;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic refresh_granted();
    if (last_grant >= 0) d[last_grant] = rand_fp();
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_empty: got id=%0d data=%0d expected no result", out_id, out_data);
      end else begin
        check("sb_out_data", 32'(out_data), 32'(q[0][7:0]));
        check("sb_out_id", 32'(out_id), 32'(q[0][9:8]));
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  // Requesters must hold valid and data until their ready is seen.
  always @(negedge clk) begin
    if (hold_chk) begin
      for (int i = 0; i < N; i++) begin
        if (pv[i] && !pr[i]) begin
          check("hold_valid", 32'(req_valid[i]), 32'd1);
          check("hold_data", d[i], pd[i]);
        end
      end
      pv = req_valid;
      pr = req_ready;
      for (int i = 0; i < N; i++) pd[i] = d[i];
    end else begin
      pv = '0;
      pr = '0;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] sv [7];
    logic [7:0]  se [7];
    sv = '{32'h3F800000, 32'h3F000000, 32'h42C8CCCD, 32'h43800000,
           32'hC2C80000, 32'h7F800000, 32'h00000000};
    se = '{8'd1, 8'd0, 8'd100, 8'd255, 8'd100, 8'd255, 8'd0};
    req_valid = '0;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) d[i] = '0;
    #2;
    do_reset();

    req_valid = 4'b0100;
    d[2] = 32'h43480000;
    out_ready = 1'b1;
    tick();
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data", 32'(out_data), 32'd200);
    check("single_id", 32'(out_id), 32'd2);
    check("single_count", 32'(conv_count), 32'd1);
    req_valid = '0;
    tick();

    for (int k = 0; k < 7; k++) begin
      req_valid = 4'b0001;
      d[0] = sv[k];
      tick();
      check("sweep_data", 32'(out_data), 32'(se[k]));
      check("sweep_id", 32'(out_id), 32'd0);
    end
    req_valid = '0;
    tick();

    req_valid = 4'b1111;
    for (int i = 0; i < N; i++) d[i] = rand_fp();
    repeat (8) begin
      tick();
      refresh_granted();
    end

    out_ready = 1'b0;
    repeat (3) tick();
    out_ready = 1'b1;
    repeat (4) begin
      tick();
      refresh_granted();
    end

    req_valid = '0;
    tick();
    req_valid = 4'b1010;
    repeat (6) begin
      tick();
      refresh_granted();
    end
    req_valid = '0;
    tick();

    hold_chk = 1'b1;
    repeat (400) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || last_grant == i) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          d[i] = rand_fp();
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    hold_chk = 1'b0;

    req_valid = 4'b1111;
    out_ready = 1'b1;
    tick();
    do_reset();
    req_valid = 4'b1010;
    d[1] = rand_fp();
    d[3] = rand_fp();
    tick();
    check("first_after_rst", 32'(out_id), 32'd1);
    req_valid = '0;
    tick();

    do_reset();
    req_valid = 4'b0001;
    d[0] = 32'h3F800000;
    out_ready = 1'b1;
    repeat (65535) tick();
    check("cnt_max", 32'(conv_count), 32'h0000FFFF);
    tick();
    check("cnt_wrap", 32'(conv_count), 32'd0);
    req_valid = '0;
    tick();
    tick();
    check("sb_drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
